// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : seg_pkg
// Purpose: Shared definitions for the 7-segment display blocks: scan FSM
//          state encoding, the all-off segment pattern and the hex-to-segment
//          lookup table (active-high, bit order {g,f,e,d,c,b,a}).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [7:0] SEG_OFF  = 8'h00;

  // Entry n holds the segment pattern for hex digit n (entry 0 is rightmost).
  localparam logic [15:0][6:0] HEX7SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : hex7seg
// Purpose: Purely combinational 4-bit hex to 7-segment decoder, active-high.
// Ports  : hex  in  4   nibble to display
//          seg  out 7   {g,f,e,d,c,b,a}
// Rev    : 1.0  initial release
// ============================================================================
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX7SEG_TABLE[hex];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : seg_scan_driver
// Purpose: Time-multiplexed 7-segment driver. Each rising edge of the divided
//          scan clock (sampled as data) advances to the next enabled digit,
//          with a fixed blanking gap at every digit change. Inputs are
//          snapshotted once per frame so a frame is never torn.
// Ports  : clk       in   1             system clock
//          rst       in   1             asynchronous active-high reset
//          scan_clk  in   1             divided scan clock, sampled as data
//          hex_data  in   4*NUM_DIGITS  digit i = hex_data[4i+3:4i]
//          digit_en  in   NUM_DIGITS    per-digit enable
//          dp_en     in   NUM_DIGITS    per-digit decimal point
//          seg_out   out  8             {dp,g,f,e,d,c,b,a}, registered
//          dig_sel   out  NUM_DIGITS    one-hot digit select or all-off
// Rev    : 1.0  initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int                  IDX_W       = $clog2(NUM_DIGITS);
  localparam logic [3:0]          BLANK_LAST  = 4'(BLANK_CYCLES - 1);
  localparam logic [7:0]          SEG_PIN_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_PIN_OFF = ACTIVE_LOW ? '1 : '0;

  // Registered state
  logic                    scan_q;
  logic [0:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              blank_cnt;
  logic [4*NUM_DIGITS-1:0] snap_hex;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic [NUM_DIGITS-1:0]   snap_dp;

  // Next-state / combinational
  logic                    tick;
  logic [IDX_W-1:0]        next_idx;
  logic [IDX_W-1:0]        first_idx;
  logic                    wrap;
  logic [0:0]              state_n;
  logic [IDX_W-1:0]        idx_n;
  logic [3:0]              cnt_n;
  logic                    load;
  logic [3:0]              show_hex;
  logic [6:0]              show_seg;
  logic [NUM_DIGITS-1:0]   dig_on;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic [7:0]              seg_n;

  assign tick = scan_clk & ~scan_q;

  // Candidate index base+step modulo NUM_DIGITS (step never exceeds NUM_DIGITS).
  function automatic logic [IDX_W-1:0] cand(input logic [IDX_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_DIGITS) sum = sum - NUM_DIGITS;
    return IDX_W'(sum);
  endfunction

  // Search downwards so the closest enabled successor wins; step NUM_DIGITS
  // lands back on idx itself, giving the inclusive wrap for a lone digit.
  always_comb begin
    next_idx = idx;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      if (snap_en[cand(idx, k)]) next_idx = cand(idx, k);
    end
  end

  // Lowest enabled digit of the incoming enables: start point of a new frame.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) first_idx = IDX_W'(i);
    end
  end

  assign wrap = (next_idx <= idx);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = blank_cnt;
    load    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (snap_en == '0) begin
          // Idle: nothing to show, keep tracking the inputs.
          load  = 1'b1;
          cnt_n = '0;
          idx_n = first_idx;
        end else if (blank_cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = blank_cnt + 4'd1;
        end
      end
      default: begin
        if (tick) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          if (wrap) begin
            // Frame boundary: take a fresh snapshot and restart at its
            // lowest enabled digit so a changed enable mask is honoured.
            load  = 1'b1;
            idx_n = first_idx;
          end else begin
            idx_n = next_idx;
          end
        end
      end
    endcase
  end

  // SHOW is never entered on a load cycle, so the snapshot regs are current.
  assign show_hex = snap_hex[{idx_n, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .hex (show_hex),
    .seg (show_seg)
  );

  always_comb begin
    dig_on        = '0;
    dig_on[idx_n] = 1'b1;
    dig_n         = DIG_PIN_OFF;
    seg_n         = SEG_PIN_OFF;
    if (state_n == ST_SHOW) begin
      dig_n = dig_on ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_n = {snap_dp[idx_n], show_seg} ^ {8{ACTIVE_LOW}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= 1'b0;
      state     <= ST_BLANK;
      idx       <= '0;
      blank_cnt <= '0;
      snap_hex  <= '0;
      snap_en   <= '0;
      snap_dp   <= '0;
      seg_out   <= SEG_PIN_OFF;
      dig_sel   <= DIG_PIN_OFF;
    end else begin
      scan_q    <= scan_clk;
      state     <= state_n;
      idx       <= idx_n;
      blank_cnt <= cnt_n;
      if (load) begin
        snap_hex <= hex_data;
        snap_en  <= digit_en;
        snap_dp  <= dp_en;
      end
      seg_out   <= seg_n;
      dig_sel   <= dig_n;
    end
  end

endmodule
`default_nettype wire
